row_sched64: RTL and testbench

Slave-side sequencer for the 64-MAC DLA main controller. It watches the master state word and drives the sram0 first-load address stream while the master is in FSLD, then the per-row compute sweep (curr_of_row / column beats) while the master is in LEFT. It returns the two completion flags the master FSM consumes: flag_fsld_end and left_done.

---
 rtl/row_sched64_pkg.sv | 34 +++
 rtl/row_col_cnt.sv | 49 ++++
 rtl/row_sched64.sv | 177 +++++++++++++++++
 tb/tb_row_sched64.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/row_sched64_pkg.sv
// Shared encodings between the DLA master FSM and the row_sched64 slave sequencer.
package row_sched64_pkg;

    localparam int MAST_FSM_BITS = 3;

    typedef enum logic [2:0] {
        M_IDLE = 3'd0,
        LEFT   = 3'd1,
        BASE   = 3'd2,
        RIGHT  = 3'd3,
        FSLD   = 3'd7
    } mast_state_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SWEEP = 2'd2,
        S_WAIT  = 2'd3
    } slv_state_e;

    // Arming decision shared by S_IDLE and the exit from S_WAIT.
    function automatic slv_state_e arm_state(input logic is_fsld, input logic is_left);
        slv_state_e st;
        if (is_fsld) begin
            st = S_LOAD;
        end else if (is_left) begin
            st = S_SWEEP;
        end else begin
            st = S_IDLE;
        end
        return st;
    endfunction

endpackage

// File: rtl/row_col_cnt.sv
// Two-level row/column beat counter with enable, synchronous clear and terminal-beat flag.
module row_col_cnt #(
    parameter int ROWS = 8,
    parameter int COLS = 9,
    parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    logic [RW-1:0] row_r;
    logic [CW-1:0] col_r;

    assign row  = row_r;
    assign col  = col_r;
    assign last = (row_r == ROW_LAST) && (col_r == COL_LAST);

    // Column advances per enabled beat; row advances when the column wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_r <= '0;
            col_r <= '0;
        end else if (clr) begin
            row_r <= '0;
            col_r <= '0;
        end else if (en) begin
            if (col_r == COL_LAST) begin
                col_r <= '0;
                if (row_r == ROW_LAST) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + RW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/row_sched64.sv
// Slave sequencer for the 64-MAC DLA: sram0 first load in FSLD, row/column sweep in LEFT.
// Optional macro ROW_SCHED_PERF_EN adds perf_fsld_cyc / perf_left_cyc cycle counters.
module row_sched64 #(
    parameter int MAST_FSM_BITS = 3,
    parameter int FSLD_LEN      = 64,
    parameter int ROW_NUM       = 8,
    parameter int COL_NUM       = 9,
    parameter int ADDR_BITS     = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [MAST_FSM_BITS-1:0]   mast_state,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    output logic                       sram0_wen,
    output logic [ADDR_BITS-1:0]       sram0_addr,
    input  logic                       mac_ready,
    output logic                       compute_en,
    output logic [$clog2(ROW_NUM)-1:0] curr_of_row,
    output logic [$clog2(COL_NUM)-1:0] col_cnt,
    output logic                       flag_fsld_end,
    output logic                       left_done
`ifdef ROW_SCHED_PERF_EN
    ,
    output logic [31:0]                perf_fsld_cyc,
    output logic [31:0]                perf_left_cyc
`endif
);

    import row_sched64_pkg::*;

    localparam int RW = $clog2(ROW_NUM);
    localparam int CW = $clog2(COL_NUM);
    localparam int AW = (FSLD_LEN > 1) ? $clog2(FSLD_LEN) : 1;

    slv_state_e    state_r;
    slv_state_e    state_nxt_s;
    logic          ld_ready_r;
    logic          sweep_r;
    logic          flag_fsld_r;
    logic          left_done_r;
    logic          served_fsld_r;
    logic          is_fsld_s;
    logic          is_left_s;
    logic          addr_clr_s;
    logic          addr_last_s;
    logic          load_last_s;
    logic [0:0]    addr_row_s;
    logic [AW-1:0] addr_col_s;
    logic          grid_clr_s;
    logic          grid_last_s;
    logic          sweep_last_s;

    assign is_fsld_s     = (mast_state == MAST_FSM_BITS'(FSLD));
    assign is_left_s     = (mast_state == MAST_FSM_BITS'(LEFT));
    assign ld_ready      = ld_ready_r;
    assign sram0_wen     = ld_valid && ld_ready_r;
    assign compute_en    = mac_ready && sweep_r;
    assign flag_fsld_end = flag_fsld_r;
    assign left_done     = left_done_r;
    assign load_last_s   = sram0_wen && addr_last_s;
    assign sweep_last_s  = compute_en && grid_last_s;
    // Counters stay cleared outside their active state and on an abort (master left early).
    assign addr_clr_s    = (state_r != S_LOAD)  || (!is_fsld_s && !load_last_s);
    assign grid_clr_s    = (state_r != S_SWEEP) || (!is_left_s && !sweep_last_s);
    // The single-row address counter keeps its row at zero, so the concatenation is the column.
    assign sram0_addr    = ADDR_BITS'({addr_row_s, addr_col_s});

    row_col_cnt #(.ROWS(1), .COLS(FSLD_LEN), .RW(1), .CW(AW)) u_addr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (addr_clr_s),
        .en    (sram0_wen),
        .row   (addr_row_s),
        .col   (addr_col_s),
        .last  (addr_last_s)
    );

    row_col_cnt #(.ROWS(ROW_NUM), .COLS(COL_NUM), .RW(RW), .CW(CW)) u_grid_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (grid_clr_s),
        .en    (compute_en),
        .row   (curr_of_row),
        .col   (col_cnt),
        .last  (grid_last_s)
    );

    // Next-state decode; completion wins over a same-cycle master state change.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: state_nxt_s = arm_state(is_fsld_s, is_left_s);
            S_LOAD: begin
                if (load_last_s) begin
                    state_nxt_s = S_WAIT;
                end else if (!is_fsld_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_LOAD;
                end
            end
            S_SWEEP: begin
                if (sweep_last_s) begin
                    state_nxt_s = S_WAIT;
                end else if (!is_left_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_SWEEP;
                end
            end
            S_WAIT: begin
                if (served_fsld_r ? !is_fsld_s : !is_left_s) begin
                    state_nxt_s = arm_state(is_fsld_s, is_left_s);
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register with registered strobes and one-cycle completion flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= S_IDLE;
            ld_ready_r    <= 1'b0;
            sweep_r       <= 1'b0;
            flag_fsld_r   <= 1'b0;
            left_done_r   <= 1'b0;
            served_fsld_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ld_ready_r  <= (state_nxt_s == S_LOAD);
            sweep_r     <= (state_nxt_s == S_SWEEP);
            flag_fsld_r <= load_last_s;
            left_done_r <= sweep_last_s;
            if (load_last_s) begin
                served_fsld_r <= 1'b1;
            end else if (sweep_last_s) begin
                served_fsld_r <= 1'b0;
            end
        end
    end

`ifdef ROW_SCHED_PERF_EN
    logic [31:0] perf_fsld_r;
    logic [31:0] perf_left_r;

    assign perf_fsld_cyc = perf_fsld_r;
    assign perf_left_cyc = perf_left_r;

    // Saturating occupancy counters, cleared on entry and held after exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fsld_r <= 32'd0;
            perf_left_r <= 32'd0;
        end else begin
            if (state_r == S_LOAD) begin
                if (perf_fsld_r != 32'hFFFF_FFFF) begin
                    perf_fsld_r <= perf_fsld_r + 32'd1;
                end
            end else if (state_nxt_s == S_LOAD) begin
                perf_fsld_r <= 32'd0;
            end
            if (state_r == S_SWEEP) begin
                if (perf_left_r != 32'hFFFF_FFFF) begin
                    perf_left_r <= perf_left_r + 32'd1;
                end
            end else if (state_nxt_s == S_SWEEP) begin
                perf_left_r <= 32'd0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_row_sched64.sv
// Directed bench for row_sched64 with a behavioural model and write/compute-beat scoreboards.
module tb_row_sched64;

    localparam int MIDLE = 0;
    localparam int MLOAD = 1;
    localparam int MSWP  = 2;
    localparam int MWAIT = 3;
    localparam logic [2:0] C_IDLE = 3'd0;
    localparam logic [2:0] C_LEFT = 3'd1;
    localparam logic [2:0] C_BASE = 3'd2;
    localparam logic [2:0] C_FSLD = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mast_state;
    logic        ld_valid;
    logic        ld_ready;
    logic        sram0_wen;
    logic [5:0]  sram0_addr;
    logic        mac_ready;
    logic        compute_en;
    logic [2:0]  curr_of_row;
    logic [3:0]  col_cnt;
    logic        flag_fsld_end;
    logic        left_done;
`ifdef ROW_SCHED_PERF_EN
    logic [31:0] perf_fsld_cyc;
    logic [31:0] perf_left_cyc;
`endif

    int checks = 0;
    int errors = 0;

    logic [5:0] addr_q[$];
    logic [6:0] rc_q[$];

    int   m_st, m_addr, m_row, m_col;
    logic m_ff, m_fl, m_served_f;
    int   n_ff, n_fl, n_wr, n_ce;

    row_sched64 dut (
        .clk           (clk),
        .reset         (reset),
        .mast_state    (mast_state),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .sram0_wen     (sram0_wen),
        .sram0_addr    (sram0_addr),
        .mac_ready     (mac_ready),
        .compute_en    (compute_en),
        .curr_of_row   (curr_of_row),
        .col_cnt       (col_cnt),
        .flag_fsld_end (flag_fsld_end),
`ifdef ROW_SCHED_PERF_EN
        .perf_fsld_cyc (perf_fsld_cyc),
        .perf_left_cyc (perf_left_cyc),
`endif
        .left_done     (left_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = MIDLE; m_addr = 0; m_row = 0; m_col = 0;
        m_ff = 1'b0; m_fl = 1'b0; m_served_f = 1'b0;
        addr_q.delete();
        rc_q.delete();
    endtask

    task automatic clear_counts();
        n_ff = 0; n_fl = 0; n_wr = 0; n_ce = 0;
    endtask

    task automatic check_all_idle(input string tag);
        check({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
        check({tag, "_wen"}, 32'(sram0_wen), 32'd0);
        check({tag, "_addr"}, 32'(sram0_addr), 32'd0);
        check({tag, "_compute_en"}, 32'(compute_en), 32'd0);
        check({tag, "_row"}, 32'(curr_of_row), 32'd0);
        check({tag, "_col"}, 32'(col_cnt), 32'd0);
        check({tag, "_flag_fsld"}, 32'(flag_fsld_end), 32'd0);
        check({tag, "_left_done"}, 32'(left_done), 32'd0);
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance model, return at posedge+1.
    task automatic cyc(input logic [2:0] ms, input logic lv, input logic mr);
        logic e_rdy, e_wen, e_ce, isf, isl, nf, nl;
        logic [5:0] a;
        logic [6:0] rc;
        mast_state = ms; ld_valid = lv; mac_ready = mr;
        e_rdy = (m_st == MLOAD);
        e_wen = e_rdy && lv;
        e_ce  = (m_st == MSWP) && mr;
        if (e_wen) addr_q.push_back(6'(m_addr));
        if (e_ce)  rc_q.push_back({3'(m_row), 4'(m_col)});
        @(negedge clk);
        check("ld_ready", 32'(ld_ready), 32'(e_rdy));
        check("sram0_wen", 32'(sram0_wen), 32'(e_wen));
        check("compute_en", 32'(compute_en), 32'(e_ce));
        check("flag_fsld_end", 32'(flag_fsld_end), 32'(m_ff));
        check("left_done", 32'(left_done), 32'(m_fl));
        check("sram0_addr", 32'(sram0_addr), 32'(m_addr));
        check("curr_of_row", 32'(curr_of_row), 32'(m_row));
        check("col_cnt", 32'(col_cnt), 32'(m_col));
        if (flag_fsld_end === 1'b1) n_ff++;
        if (left_done === 1'b1) n_fl++;
        if (sram0_wen === 1'b1) begin
            n_wr++;
            if (addr_q.size() == 0) begin
                check("wr_sb_underflow", 32'(addr_q.size()), 32'd1);
            end else begin
                a = addr_q.pop_front();
                check("wr_sb_addr", 32'(sram0_addr), 32'(a));
            end
        end
        if (compute_en === 1'b1) begin
            n_ce++;
            if (rc_q.size() == 0) begin
                check("ce_sb_underflow", 32'(rc_q.size()), 32'd1);
            end else begin
                rc = rc_q.pop_front();
                check("ce_sb_rowcol", 32'({curr_of_row, col_cnt}), 32'(rc));
            end
        end
        isf = (ms == C_FSLD);
        isl = (ms == C_LEFT);
        nf = 1'b0; nl = 1'b0;
        case (m_st)
            MIDLE: m_st = isf ? MLOAD : (isl ? MSWP : MIDLE);
            MLOAD: begin
                if (e_wen && m_addr == 63) begin
                    nf = 1'b1; m_addr = 0; m_st = MWAIT; m_served_f = 1'b1;
                end else if (!isf) begin
                    m_addr = 0; m_st = MIDLE;
                end else if (e_wen) begin
                    m_addr++;
                end
            end
            MSWP: begin
                if (e_ce && m_row == 7 && m_col == 8) begin
                    nl = 1'b1; m_row = 0; m_col = 0; m_st = MWAIT; m_served_f = 1'b0;
                end else if (!isl) begin
                    m_row = 0; m_col = 0; m_st = MIDLE;
                end else if (e_ce) begin
                    if (m_col == 8) begin m_col = 0; m_row++; end
                    else m_col++;
                end
            end
            default: begin
                if (m_served_f ? !isf : !isl) m_st = isf ? MLOAD : (isl ? MSWP : MIDLE);
            end
        endcase
        m_ff = nf; m_fl = nl;
        @(posedge clk); #1;
    endtask

    initial begin
        logic reached;
        reset = 1'b0; mast_state = C_IDLE; ld_valid = 1'b0; mac_ready = 1'b0;
        model_reset();
        clear_counts();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_idle("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // Full load, ld_valid held high.
        for (int i = 0; i < 66; i++) cyc(C_FSLD, 1'b1, 1'b0);
        repeat (2) cyc(C_IDLE, 1'b0, 1'b0);
        check("full_load_flags", 32'(n_ff), 32'd1);
        check("full_load_writes", 32'(n_wr), 32'd64);

        // Stalled load, ld_valid alternating.
        clear_counts();
        for (int i = 0; i < 136; i++) cyc(C_FSLD, (i % 2) == 0, 1'b0);
        repeat (2) cyc(C_IDLE, 1'b0, 1'b0);
        check("stall_load_flags", 32'(n_ff), 32'd1);
        check("stall_load_writes", 32'(n_wr), 32'd64);

        // Full sweep, then a master state outside the served one releases S_WAIT.
        clear_counts();
        for (int i = 0; i < 75; i++) cyc(C_LEFT, 1'b0, 1'b1);
        repeat (2) cyc(C_BASE, 1'b0, 1'b1);
        check("sweep_done_pulses", 32'(n_fl), 32'd1);
        check("sweep_beats", 32'(n_ce), 32'd72);

        // Abort after 10 beats, then restart from address 0.
        clear_counts();
        for (int i = 0; i < 11; i++) cyc(C_FSLD, 1'b1, 1'b0);
        repeat (2) cyc(C_IDLE, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(C_FSLD, 1'b1, 1'b0);
        repeat (2) cyc(C_IDLE, 1'b0, 1'b0);
        check("abort_no_flag", 32'(n_ff), 32'd0);
        check("abort_writes", 32'(n_wr), 32'd15);

        // Asynchronous reset in the middle of a sweep at row 3, column 4.
        clear_counts();
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc(C_LEFT, 1'b0, 1'b1);
            if (m_st == MSWP && m_row == 3 && m_col == 4) begin
                reached = 1'b1;
                break;
            end
        end
        check("midsweep_reached", 32'(reached), 32'd1);
        mast_state = C_LEFT; mac_ready = 1'b1;
        check("pre_reset_row", 32'(curr_of_row), 32'd3);
        check("pre_reset_col", 32'(col_cnt), 32'd4);
        #1 reset = 1'b0;
        #1 check_all_idle("async_reset");
        model_reset();
        @(posedge clk); #1;
        mast_state = C_IDLE;
        reset = 1'b1;
        repeat (5) cyc(C_IDLE, 1'b0, 1'b1);
        check("reset_no_left_done", 32'(n_fl), 32'd0);

`ifdef ROW_SCHED_PERF_EN
        // Sweep with five stalled cycles.
        clear_counts();
        for (int i = 0; i < 82; i++) cyc(C_LEFT, 1'b0, !(i >= 10 && i < 15));
        check("perf_left_cyc", perf_left_cyc, 32'd77);
        repeat (2) cyc(C_IDLE, 1'b0, 1'b0);
        check("perf_left_hold", perf_left_cyc, 32'd77);
        check("perf_sweep_done", 32'(n_fl), 32'd1);
`endif

        check("wr_sb_drained", 32'(addr_q.size()), 32'd0);
        check("ce_sb_drained", 32'(rc_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
